// File: rtl/vram_arb_pkg.sv
// Shared types and default widths for the display RAM arbiter.
package vram_arb_pkg;

    localparam int VRAM_ADDR_W = 13;  // 8K bytes of display RAM
    localparam int VRAM_DATA_W = 8;

    // Owner of the single RAM access slot in a given cycle
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_CPU  = 2'd2
    } gnt_e;

endpackage

// File: rtl/vram_arb_hold.sv
// One-entry hold buffer for a video fetch address that lost arbitration.
// A push in the same cycle as a pop replaces the entry, so the buffer stays full.
module vram_arb_hold #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] addr_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic              full
);

    logic [ADDR_W-1:0] addr_q;

    // Entry register: push wins over pop so a served entry can be refilled at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full   <= 1'b0;
            addr_q <= '0;
        end else if (push) begin
            full   <= 1'b1;
            addr_q <= addr_in;
        end else if (pop) begin
            full   <= 1'b0;
        end
    end

    assign addr_out = addr_q;

endmodule

// File: rtl/vram_arbiter.sv
// Display RAM arbiter: shares one synchronous RAM port between the video
// fetch path and the CPU, one access per clk cycle. Video has priority until
// it has starved a waiting CPU for STARVE_MAX grants in a row.
// Optional statistics: define VRAM_ARBITER_STATS_EN to add ovr_count and
// cpu_wait_max outputs.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W     = VRAM_ADDR_W,
    parameter int DATA_W     = VRAM_DATA_W,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    // video side
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    // CPU side
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    // RAM side
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              vid_overrun
`ifdef VRAM_ARBITER_STATS_EN
    ,
    output logic [15:0]       ovr_count,
    output logic [7:0]        cpu_wait_max
`endif
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    gnt_e              gnt;
    logic              hold_full;
    logic [ADDR_W-1:0] hold_addr;
    logic              hold_push;
    logic              hold_pop;
    logic              vid_pending;
    logic [ADDR_W-1:0] vid_sel_addr;
    logic              cpu_busy;
    logic              cpu_pending;
    logic              cpu_we_q;
    logic [SW-1:0]     starve_cnt;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              vid_drop;

    assign vid_pending  = vid_req | hold_full;
    assign vid_sel_addr = hold_full ? hold_addr : vid_addr;  // older entry first
    assign cpu_pending  = cpu_req & ~cpu_busy;

    // Grant selection; nothing is granted while reset is asserted
    always_comb begin
        gnt = GNT_NONE;
        if (!reset) begin
            if (vid_pending && (starve_cnt < STARVE_LIM)) gnt = GNT_VID;
            else if (cpu_pending)                          gnt = GNT_CPU;
            else if (vid_pending)                          gnt = GNT_VID;
        end
    end

    // A new strobe enters the hold unless it is served directly; with the hold
    // full it can only enter if the held entry leaves this cycle, else it drops.
    assign hold_pop  = hold_full & (gnt == GNT_VID);
    assign hold_push = vid_req & (hold_full ? (gnt == GNT_VID) : (gnt != GNT_VID));
    assign vid_drop  = vid_req & hold_full & (gnt != GNT_VID);

    vram_arb_hold #(.ADDR_W(ADDR_W)) u_hold (
        .clk      (clk),
        .reset    (reset),
        .push     (hold_push),
        .pop      (hold_pop),
        .addr_in  (vid_addr),
        .addr_out (hold_addr),
        .full     (hold_full)
    );

    // RAM port mux driven straight from the granted requester
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        case (gnt)
            GNT_VID: ram_addr = vid_sel_addr;
            GNT_CPU: begin
                ram_addr  = cpu_addr;
                ram_we    = cpu_we;
                ram_wdata = cpu_wdata;
            end
            default: ;
        endcase
    end

    // Grant bookkeeping: response strobes, CPU busy window, starvation counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vid_valid   <= 1'b0;
            cpu_ack     <= 1'b0;
            cpu_busy    <= 1'b0;
            cpu_we_q    <= 1'b0;
            starve_cnt  <= '0;
            vid_overrun <= 1'b0;
        end else begin
            vid_valid <= (gnt == GNT_VID);
            cpu_ack   <= (gnt == GNT_CPU);
            cpu_busy  <= (gnt == GNT_CPU);
            if (gnt == GNT_CPU) cpu_we_q <= cpu_we;
            if (!cpu_pending || gnt == GNT_CPU) starve_cnt <= '0;
            else if (gnt == GNT_VID && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
            if (vid_drop) vid_overrun <= 1'b1;
        end
    end

    // Read data is returned in the ack cycle; writes leave the last read value
    assign cpu_rdata = (cpu_ack && !cpu_we_q) ? ram_rdata : cpu_rdata_q;
    assign vid_data  = vid_valid ? ram_rdata : '0;

    // Keep the last presented CPU read value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cpu_rdata_q <= '0;
        else       cpu_rdata_q <= cpu_rdata;
    end

`ifdef VRAM_ARBITER_STATS_EN
    logic [7:0] wait_cnt;

    // Drop counter and worst-case CPU wait (cycles pending before grant)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr_count    <= '0;
            cpu_wait_max <= '0;
            wait_cnt     <= '0;
        end else begin
            if (vid_drop && ovr_count != 16'hFFFF) ovr_count <= ovr_count + 16'd1;
            if (gnt == GNT_CPU) begin
                if (wait_cnt > cpu_wait_max) cpu_wait_max <= wait_cnt;
                wait_cnt <= '0;
            end else if (!cpu_pending) begin
                wait_cnt <= '0;
            end else if (wait_cnt != 8'hFF) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 1-cycle synchronous RAM.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        vid_req;
    logic [12:0] vid_addr;
    logic [7:0]  vid_data;
    logic        vid_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        vid_overrun;
`ifdef VRAM_ARBITER_STATS_EN
    logic [15:0] ovr_count;
    logic [7:0]  cpu_wait_max;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .vid_req     (vid_req),
        .vid_addr    (vid_addr),
        .vid_data    (vid_data),
        .vid_valid   (vid_valid),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ack     (cpu_ack),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .vid_overrun (vid_overrun)
`ifdef VRAM_ARBITER_STATS_EN
        ,
        .ovr_count   (ovr_count),
        .cpu_wait_max(cpu_wait_max)
`endif
    );

    // Background RAM contents are a fixed address hash; written bytes override it
    function automatic logic [7:0] fdat(int a);
        logic [12:0] x;
        x = 13'(a);
        return x[7:0] ^ {3'b000, x[12:8]} ^ 8'h5A;
    endfunction

    logic [7:0] wmem [0:8191];
    bit         wflag [0:8191];

    always @(posedge clk) begin
        if (ram_we) begin
            wmem[ram_addr]  <= ram_wdata;
            wflag[ram_addr] <= 1'b1;
        end
        ram_rdata <= wflag[ram_addr] ? wmem[ram_addr] : fdat(int'(ram_addr));
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

        // reset state
        #3;
        chk("rst_vid_valid", vid_valid, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_overrun", vid_overrun, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_vid_data", vid_data, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        tick(); tick();
        reset = 1'b0;

        // video only: streamed addresses 0..7, data one cycle behind
        for (int i = 0; i < 9; i++) begin
            tick();
            vid_req = (i < 8); vid_addr = 13'(i);
            mid();
            if (i < 8) chk("vo_ram_addr", ram_addr, i);
            if (i > 0) begin
                chk("vo_vid_valid", vid_valid, 1);
                chk("vo_vid_data", vid_data, fdat(i - 1));
            end
        end
        tick(); mid();
        chk("vo_idle_valid", vid_valid, 0);
        chk("vo_overrun", vid_overrun, 0);

        // contention: CPU read wins on the 4th cycle, held strobe served next
        tick(); vid_req = 1'b1; vid_addr = 13'h10; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1234;
        mid(); chk("ct_c0_addr", ram_addr, 13'h10);
        tick(); vid_addr = 13'h11; mid(); chk("ct_c1_addr", ram_addr, 13'h11);
        tick(); vid_addr = 13'h12; mid(); chk("ct_c2_addr", ram_addr, 13'h12);
        tick(); vid_addr = 13'h13; mid();
        chk("ct_cpu_gnt_addr", ram_addr, 13'h1234);
        chk("ct_c3_vid_data", vid_data, fdat('h12));
        tick(); vid_addr = 13'h14; cpu_req = 1'b0; mid();
        chk("ct_cpu_ack", cpu_ack, 1);
        chk("ct_cpu_rdata", cpu_rdata, fdat('h1234));
        chk("ct_hold_addr", ram_addr, 13'h13);
        chk("ct_c4_vid_valid", vid_valid, 0);
        tick(); vid_req = 1'b0; mid();
        chk("ct_c5_addr", ram_addr, 13'h14);
        chk("ct_c5_vid_data", vid_data, fdat('h13));
        tick(); mid();
        chk("ct_c6_vid_data", vid_data, fdat('h14));
        chk("ct_c6_idle_addr", ram_addr, 0);
        chk("ct_rdata_hold", cpu_rdata, fdat('h1234));

        // CPU write then video readback
        tick(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0100; cpu_wdata = 8'hA5; mid();
        chk("wr_ram_we", ram_we, 1);
        chk("wr_ram_addr", ram_addr, 13'h0100);
        chk("wr_ram_wdata", ram_wdata, 8'hA5);
        tick(); cpu_req = 1'b0; cpu_we = 1'b0; mid();
        chk("wr_cpu_ack", cpu_ack, 1);
        chk("wr_ram_we_off", ram_we, 0);
        chk("wr_rdata_kept", cpu_rdata, fdat('h1234));
        tick(); vid_req = 1'b1; vid_addr = 13'h0100; mid();
        tick(); vid_req = 1'b0; mid();
        chk("wr_readback", vid_data, 8'hA5);

        // back-to-back CPU reads: grant, ack, grant, ack ...
        for (int i = 0; i < 7; i++) begin
            tick(); cpu_req = (i < 5); cpu_addr = 13'h0200; mid();
            chk("bb_cpu_ack", cpu_ack, (i % 2 == 1));
            chk("bb_ram_addr", ram_addr, (i % 2 == 0 && i < 5) ? 'h200 : 0);
            if (i % 2 == 1) chk("bb_cpu_rdata", cpu_rdata, fdat('h200));
        end

        // overrun: hold fills on the first CPU grant, drops on the second
        for (int i = 0; i < 12; i++) begin
            tick(); vid_req = (i < 11); vid_addr = 13'(32'h20 + i);
            cpu_req = (i < 9); cpu_we = 1'b0; cpu_addr = 13'h0300;
            mid();
            if (i == 3) chk("ov_gnt1_addr", ram_addr, 13'h0300);
            if (i == 8) begin
                chk("ov_gnt2_addr", ram_addr, 13'h0300);
                chk("ov_not_yet", vid_overrun, 0);
            end
            if (i == 9) begin
                chk("ov_set", vid_overrun, 1);
                chk("ov_hold_kept", ram_addr, 13'h27);
`ifdef VRAM_ARBITER_STATS_EN
                chk("ov_count", ovr_count, 1);
                chk("ov_wait_max", cpu_wait_max, 3);
`endif
            end
            if (i == 10) chk("ov_next_addr", ram_addr, 13'h29);
            if (i == 11) chk("ov_sticky", vid_overrun, 1);
        end
        tick(); vid_req = 1'b0; mid();

        // reset asserted during a CPU grant cycle
        tick(); cpu_req = 1'b1; cpu_addr = 13'h0400; mid();
        chk("rm_gnt_addr", ram_addr, 13'h0400);
        #2 reset = 1'b1;
        #1;
        chk("rm_cpu_ack", cpu_ack, 0);
        chk("rm_vid_valid", vid_valid, 0);
        chk("rm_overrun", vid_overrun, 0);
        chk("rm_ram_we", ram_we, 0);
        chk("rm_ram_addr", ram_addr, 0);
        chk("rm_vid_data", vid_data, 0);
        chk("rm_cpu_rdata", cpu_rdata, 0);
        tick(); reset = 1'b0; cpu_req = 1'b0; vid_req = 1'b1; vid_addr = 13'h0005; mid();
        chk("rm_no_ack", cpu_ack, 0);
        chk("rm_first_gnt", ram_addr, 13'h0005);
        tick(); vid_req = 1'b0; mid();
        chk("rm_vid_valid2", vid_valid, 1);
        chk("rm_vid_data2", vid_data, fdat(5));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, meaning display RAM address width (8K bytes).
REQ-002 SHALL have parameter DATA_W, default 8, meaning display RAM data width.
REQ-003 SHALL have parameter STARVE_MAX, default 3, meaning the maximum number of consecutive video grants while a CPU request waits.
REQ-004 SHALL have ports: clk in 1 (single clock, pixel clock domain); reset in 1 (asynchronous, active-high).
REQ-005 SHALL have video-side ports: vid_req in 1 (fetch strobe); vid_addr in ADDR_W; vid_data out DATA_W; vid_valid out 1.
REQ-006 SHALL have CPU-side ports: cpu_req in 1 (level); cpu_we in 1; cpu_addr in ADDR_W; cpu_wdata in DATA_W; cpu_rdata out DATA_W; cpu_ack out 1.
REQ-007 SHALL have RAM-side ports: ram_addr out ADDR_W; ram_we out 1; ram_wdata out DATA_W; ram_rdata in DATA_W (synchronous RAM, 1-cycle read latency).
REQ-008 SHALL have port vid_overrun out 1, a sticky flag.

Function
REQ-009 SHALL issue at most one RAM access per clk cycle, granted to NONE, VID or CPU.
REQ-010 SHALL hold a video request in a 1-entry hold buffer when it is not granted in its strobe cycle; vid_pending = vid_req OR hold full.
REQ-011 SHALL apply this grant rule: if vid_pending and starve_cnt < STARVE_MAX, grant VID; else if cpu_pending, grant CPU; else if vid_pending, grant VID; else grant NONE.
REQ-012 SHALL define cpu_pending = cpu_req AND NOT cpu_busy.
REQ-013 SHALL serve the held entry before a same-cycle new vid_req; the new strobe then enters the hold.
REQ-014 SHALL increment starve_cnt, saturating at STARVE_MAX, on every VID grant while cpu_pending; SHALL clear it on a CPU grant or whenever cpu_pending is 0.
REQ-015 SHALL set cpu_busy in the CPU grant cycle and clear it in the following cycle (the cpu_ack cycle), so CPU grants are at least 2 cycles apart.
REQ-016 SHALL latch cpu_addr, cpu_we and cpu_wdata only in the CPU grant cycle; the CPU holds them stable until cpu_ack.
REQ-017 SHALL drive ram_addr/ram_we/ram_wdata combinationally from the granted requester; ram_we=1 only for a CPU write grant.
REQ-018 SHALL pulse vid_valid for 1 cycle, exactly 1 cycle after a VID grant, with vid_data = ram_rdata.
REQ-019 SHALL pulse cpu_ack for 1 cycle, exactly 1 cycle after a CPU grant; cpu_rdata = ram_rdata for reads, and holds its prior value for writes.
REQ-020 SHALL set vid_overrun when vid_req arrives while the hold is full and the held entry is not granted that cycle; the new request is dropped.
REQ-021 SHALL treat a CPU request that is still asserted in its ack cycle as a new request, eligible the cycle after.

Reset
REQ-022 SHALL, on reset asserted, immediately clear the hold buffer, starve_cnt, cpu_busy, vid_valid, cpu_ack, vid_overrun and ram_we, and drive vid_data, cpu_rdata and ram_addr to 0.
REQ-023 SHALL produce no vid_valid or cpu_ack for any grant in flight when reset asserts mid-access; the first grant is possible in the first cycle after reset deasserts.

Configuration
REQ-024 SHALL, with VRAM_ARBITER_STATS_EN defined, add output ovr_count (16-bit, saturating; counts dropped video requests) and output cpu_wait_max (8-bit; largest number of cycles from cpu_req rise to CPU grant).
REQ-025 SHALL, without VRAM_ARBITER_STATS_EN, omit ovr_count, cpu_wait_max and their logic; vid_overrun remains in both builds.

Structure
REQ-026 SHALL place the grant enum (GNT_NONE, GNT_VID, GNT_CPU) and the default ADDR_W/DATA_W constants in shared package vram_arb_pkg.
REQ-027 SHALL implement the 1-entry video hold as sub-module vram_arb_hold (ports: push, pop, addr in/out, full).

Verification
REQ-028 Video only: vid_req every cycle, addresses 0x0000..0x0007 -> vid_valid every cycle from cycle 1 with data matching RAM in order, vid_overrun=0.
REQ-029 Contention: vid_req continuous, cpu_req read at 0x1234 -> CPU granted on the 4th cycle (after 3 VID grants); cpu_ack 1 cycle later with cpu_rdata=RAM[0x1234]; the blocked video strobe is served from the hold next.
REQ-030 CPU write: cpu_we=1, addr 0x0100, data 0xA5, no video -> ram_we pulses 1 cycle; cpu_ack 1 cycle later; a subsequent video read of 0x0100 returns 0xA5.
REQ-031 Overrun: vid_req every cycle with cpu_req continuously asserted -> vid_overrun sets on the first CPU-granted cycle after the hold fills, and stays 1; with VRAM_ARBITER_STATS_EN, ovr_count increments per drop.
REQ-032 Back-to-back CPU: cpu_req held high through 3 accesses, no video -> cpu_ack every 2nd cycle, with no grant in the ack cycles.
REQ-033 Reset mid-access: assert reset in a CPU grant cycle -> no cpu_ack; all outputs 0 asynchronously.
